pq_ctrl: RTL and testbench

PQ_CTRL -- requirements
Module: pq_ctrl

---
 rtl/pq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pq_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pq_ctrl.sv
// Priority-queue host controller: sequences push/pop/drop commands
// to the head cell of a sorted array and returns one response each.
module pq_ctrl #(
  parameter int IW    = 4,
  parameter int PW    = 8,
  parameter int DEPTH = 8,
  parameter int TMO   = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [1:0]                 req_op_i,
  input  logic [IW-1:0]              req_id_i,
  input  logic [PW-1:0]              req_prio_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [IW-1:0]              rsp_id_o,
  output logic [PW-1:0]              rsp_prio_o,
  output logic                       rsp_err_o,
  output logic                       push_o,
  output logic                       pop_o,
  output logic                       drop_o,
  output logic [IW-1:0]              id_o,
  output logic [PW-1:0]              prio_o,
  output logic [IW-1:0]              drop_id_o,
  input  logic                       push_vld_i,
  input  logic                       pop_vld_i,
  input  logic                       drop_vld_i,
  input  logic                       drop_hit_i,
  input  logic [IW-1:0]              head_id_i,
  input  logic [PW-1:0]              head_prio_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TMO + 2);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);
  localparam logic [TW-1:0] TMOC  = TW'(TMO);
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_DROP = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [IW-1:0] id_q, id_d;
  logic [PW-1:0] prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [IW-1:0] rid_q, rid_d;
  logic [PW-1:0] rprio_q, rprio_d;
  logic          rerr_q, rerr_d;

  logic full, empty, illegal, ack;
  logic is_push, is_pop, is_drop;

  assign full    = (cnt_q == FULLC);
  assign empty   = (cnt_q == '0);
  assign is_push = (op_q == OP_PUSH);
  assign is_pop  = (op_q == OP_POP);
  assign is_drop = (op_q == OP_DROP);
  assign ack     = (is_push && push_vld_i) ||
                   (is_pop && pop_vld_i) ||
                   (is_drop && drop_vld_i);

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_id_o    = rid_q;
  assign rsp_prio_o  = rprio_q;
  assign rsp_err_o   = rerr_q;
  assign id_o        = id_q;
  assign prio_o      = prio_q;
  assign drop_id_o   = id_q;
  assign count_o     = cnt_q;
  assign full_o      = full;
  assign empty_o     = empty;

  // Reject requests the array cannot honour
  always_comb begin
    illegal = 1'b1;
    unique case (1'b1)
      is_push: illegal = (id_q == '0) || full;
      is_pop:  illegal = empty;
      is_drop: illegal = (id_q == '0) || empty;
      default: illegal = 1'b1;
    endcase
  end

  // Next-state, command pulses and response capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    rid_d   = rid_q;
    rprio_d = rprio_q;
    rerr_d  = rerr_q;
    push_o  = 1'b0;
    pop_o   = 1'b0;
    drop_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          id_d    = req_id_i;
          prio_d  = req_prio_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        rid_d   = id_q;
        rprio_d = '0;
        rerr_d  = illegal;
        if (illegal) begin
          state_d = RESP;
        end else begin
          push_o  = is_push;
          pop_o   = is_pop;
          drop_o  = is_drop;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack) begin
          state_d = RESP;
          rerr_d  = 1'b0;
          unique case (1'b1)
            is_push: begin
              if (!full) cnt_d = cnt_q + CW'(1);
            end
            is_pop: begin
              rid_d   = head_id_i;
              rprio_d = head_prio_i;
              if (!empty) cnt_d = cnt_q - CW'(1);
            end
            default: begin
              rerr_d = !drop_hit_i;
              if (drop_hit_i && !empty) cnt_d = cnt_q - CW'(1);
            end
          endcase
        end else if (tmo_q == TMOC) begin
          rerr_d  = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      id_q    <= '0;
      prio_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rid_q   <= '0;
      rprio_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rid_q   <= rid_d;
      rprio_q <= rprio_d;
      rerr_q  <= rerr_d;
    end
  end

endmodule

// File: tb/tb_pq_ctrl.sv
// Randomized self-checking bench for pq_ctrl with a transaction-level
// occupancy model; the bench also plays the head cell.
module tb_pq_ctrl;
  localparam int IW = 4;
  localparam int PW = 8;
  localparam int DEPTH = 8;
  localparam int TMO = 15;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk_i = 1'b0;
  logic rst_ni;
  logic req_valid_i, req_ready_o;
  logic [1:0] req_op_i;
  logic [IW-1:0] req_id_i;
  logic [PW-1:0] req_prio_i;
  logic rsp_valid_o, rsp_ready_i;
  logic [IW-1:0] rsp_id_o;
  logic [PW-1:0] rsp_prio_o;
  logic rsp_err_o;
  logic push_o, pop_o, drop_o;
  logic [IW-1:0] id_o, drop_id_o;
  logic [PW-1:0] prio_o;
  logic push_vld_i, pop_vld_i, drop_vld_i, drop_hit_i;
  logic [IW-1:0] head_id_i;
  logic [PW-1:0] head_prio_i;
  logic [CW-1:0] count_o;
  logic full_o, empty_o;

  pq_ctrl #(.IW(IW), .PW(PW), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_id_i(req_id_i), .req_prio_i(req_prio_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_prio_o(rsp_prio_o), .rsp_err_o(rsp_err_o),
    .push_o(push_o), .pop_o(pop_o), .drop_o(drop_o),
    .id_o(id_o), .prio_o(prio_o), .drop_id_o(drop_id_o),
    .push_vld_i(push_vld_i), .pop_vld_i(pop_vld_i),
    .drop_vld_i(drop_vld_i), .drop_hit_i(drop_hit_i),
    .head_id_i(head_id_i), .head_prio_i(head_prio_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int mcnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One host transaction; d<0 means the head cell never acknowledges.
  task automatic xact(input logic [1:0] op, input logic [IW-1:0] id,
                      input logic [PW-1:0] pr, input int d,
                      input logic hit, input logic [IW-1:0] hid,
                      input logic [PW-1:0] hpr, input int rdly);
    bit legal;
    int lat_e, lat, ncmd, w;
    logic [IW-1:0] eid;
    logic [PW-1:0] epr;
    logic eerr;
    logic [2:0] ecmd;
    legal = (op == 2'd0 && id != 0 && mcnt < DEPTH) ||
            (op == 2'd1 && mcnt > 0) ||
            (op == 2'd2 && id != 0 && mcnt > 0);
    ecmd = (op == 2'd0) ? 3'b100 : (op == 2'd1) ? 3'b010 : 3'b001;
    eid = id; epr = '0; eerr = 1'b1;
    if (!legal) lat_e = 2;
    else if (d < 0 || d > TMO) lat_e = TMO + 3;
    else begin
      lat_e = 3 + d;
      case (op)
        2'd0: begin eerr = 0; mcnt++; end
        2'd1: begin eerr = 0; eid = hid; epr = hpr; mcnt--; end
        default: begin eerr = !hit; if (hit) mcnt--; end
      endcase
    end
    w = 0;
    @(negedge clk_i);
    while (!req_ready_o && w < 50) begin w++; @(negedge clk_i); end
    chk("req_ready", req_ready_o, 1);
    req_valid_i = 1; req_op_i = op; req_id_i = id; req_prio_i = pr;
    ncmd = 0; lat = -1;
    for (int i = 1; i <= TMO + 10 && lat < 0; i++) begin
      @(negedge clk_i);
      req_valid_i = 0;
      push_vld_i = 0; pop_vld_i = 0; drop_vld_i = 0; drop_hit_i = 0;
      if (push_o | pop_o | drop_o) begin
        ncmd++;
        chk("cmd_op", {push_o, pop_o, drop_o}, ecmd);
        chk("cmd_id", (op == 2'd2) ? drop_id_o : id_o, id);
        if (op == 2'd0) chk("cmd_prio", prio_o, pr);
      end
      if (legal && d >= 0 && i == 2 + d) begin
        push_vld_i = (op == 2'd0);
        pop_vld_i  = (op == 2'd1);
        drop_vld_i = (op == 2'd2);
        drop_hit_i = hit; head_id_i = hid; head_prio_i = hpr;
      end
      if (rsp_valid_o) lat = i;
    end
    chk("latency", lat, lat_e);
    chk("ncmd", ncmd, legal ? 1 : 0);
    if (lat < 0) return;
    for (int r = 0; r <= rdly; r++) begin
      if (r > 0) @(negedge clk_i);
      chk("rsp_valid", rsp_valid_o, 1);
      chk("rsp_id", rsp_id_o, eid);
      chk("rsp_prio", rsp_prio_o, epr);
      chk("rsp_err", rsp_err_o, eerr);
      chk("busy_ready", req_ready_o, 0);
    end
    rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;
    chk("rsp_done", rsp_valid_o, 0);
    chk("count", count_o, mcnt);
    chk("full", full_o, mcnt == DEPTH);
    chk("empty", empty_o, mcnt == 0);
  endtask

  initial begin
    rst_ni = 0; req_valid_i = 0; req_op_i = 0; req_id_i = 0; req_prio_i = 0;
    rsp_ready_i = 0; push_vld_i = 0; pop_vld_i = 0; drop_vld_i = 0;
    drop_hit_i = 0; head_id_i = 0; head_prio_i = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_rspv", rsp_valid_o, 0);
    chk("rst_cmds", {push_o, pop_o, drop_o, rsp_err_o}, 0);
    chk("rst_data", {id_o, prio_o, drop_id_o, rsp_id_o, rsp_prio_o}, 0);
    rst_ni = 1;

    xact(2'd1, 4'd0, 8'h00, 0, 0, 0, 0, 0);
    xact(2'd0, 4'd3, 8'h20, 1, 0, 0, 0, 0);
    while (mcnt < DEPTH)
      xact(2'd0, IW'(mcnt + 1), PW'($urandom), $urandom_range(0, 3),
           0, 0, 0, 0);
    xact(2'd0, 4'd7, 8'h11, 0, 0, 0, 0, 1);
    chk("full_hold", full_o, 1);
    xact(2'd1, 4'd0, 8'h00, 2, 0, 4'd5, 8'h7F, 0);
    xact(2'd2, 4'd9, 8'h00, 1, 0, 0, 0, 0);
    xact(2'd2, 4'd9, 8'h00, 0, 1, 0, 0, 0);
    xact(2'd0, 4'd4, 8'h44, -1, 0, 0, 0, 4);
    xact(2'd3, 4'd2, 8'h01, 0, 0, 0, 0, 1);

    for (int n = 0; n < 80; n++) begin
      int r;
      logic [1:0] op;
      logic [IW-1:0] id;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      id = ($urandom_range(0, 7) == 0) ? '0 : IW'($urandom_range(1, 15));
      xact(op, id, PW'($urandom),
           ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 4),
           1'($urandom), IW'($urandom_range(1, 15)), PW'($urandom),
           $urandom_range(0, 3));
    end

    // Abort a push mid-flight with reset
    @(negedge clk_i);
    if (mcnt == DEPTH) xact(2'd1, 4'd1, 8'h0, 0, 0, 4'd1, 8'h1, 0);
    @(negedge clk_i);
    req_valid_i = 1; req_op_i = 2'd0; req_id_i = 4'd6; req_prio_i = 8'h66;
    repeat (3) @(negedge clk_i);
    req_valid_i = 0;
    rst_ni = 0;
    mcnt = 0;
    #1;
    chk("abort_rspv", rsp_valid_o, 0);
    chk("abort_count", count_o, 0);
    chk("abort_cmds", {push_o, pop_o, drop_o, rsp_err_o, full_o}, 0);
    chk("abort_empty", empty_o, 1);
    @(negedge clk_i);
    rst_ni = 1;
    repeat (4) begin
      @(negedge clk_i);
      chk("abort_norsp", rsp_valid_o, 0);
    end
    xact(2'd0, 4'd8, 8'h80, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
